wide_add_seq: RTL
=================

Name: wide_add_seq

Overview:
Multi-cycle sequencer that adds two WIDTH-bit operands by time-sharing one 4-bit ripple-carry adder slice, processing one nibble per clock, LSB first.
Carry is held in a register between nibbles.
Valid/ready handshakes on both input and output let it sit between an operand source and a result sink in the adder test and datapath hierarchy.
Trades latency (WIDTH/4 cycles) for area versus a flat WIDTH-bit adder.

Parameters:
WIDTH, 16, operand/result width in bits; multiple of 4, >= 4; NIBBLES = WIDTH/4.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand request
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for nibble 0
out_valid  output  1  result available (high only in DONE)
out_ready  input  1  sink accepts result
sum  output  WIDTH  result, registered
carry  output  1  final carry-out, registered
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, active-high): state=IDLE, nibble index=0, sum=0, carry=0, out_valid=0, busy=0.
  - in_ready is decoded from state, so it is 1 while in reset.
  - Reset asserted mid-operation aborts immediately; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: capture a, b into operand registers; load carry register=cin; idx=0; go to RUN.
  - The operands are held internally, so a/b/cin may change after the accept edge without affecting the result.
- RUN, one nibble per edge:
  - slice inputs: a_reg[4*idx+:4], b_reg[4*idx+:4], carry register.
  - The slice output is written into sum[4*idx+:4]; the carry register takes the slice carry-out; idx increments.
  - When idx==NIBBLES-1 at the edge, go to DONE and reset idx to 0.
- DONE:
  - out_valid=1; sum and carry are stable.
  - On out_ready go to IDLE.
  - out_valid may therefore be high for a single cycle if out_ready is already high.
- Latency: out_valid rises exactly NIBBLES edges after the accept edge (4 for WIDTH=16). Throughput is one operation per NIBBLES+2 cycles at best.
- No bypass: a new accept is possible only in the cycle after leaving DONE. in_valid during RUN/DONE is ignored, since in_ready=0.
- sum/carry are meaningful only while out_valid=1.
  - They show partial values during RUN.
  - They hold the last result in IDLE until the next accept.
- Arithmetic is unsigned modulo 2^WIDTH; carry = bit WIDTH of a+b+cin.
- WIDTH=4 degenerates to a single RUN cycle.

Optional Feature:
Macro WIDE_ADD_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), captured at the accept edge alongside the operands.
  - op_sub=1: b_reg is stored inverted, and the carry register loads 1, ignoring cin.
  - Result = a-b mod 2^WIDTH; carry=1 means no borrow (a>=b).
  - op_sub=0 behaves exactly as the base block.
- Undefined: no op_sub port; add only.

Decomposition:
- Shared package wide_add_pkg:
  - state enum (IDLE, RUN, DONE)
  - NIBBLE_W=4 constant
  - function computing NIBBLES from WIDTH
- Sub-module add4_slice: combinational 4-bit ripple-carry slice (a4, b4, ci -> s4, co), built from 1-bit full adders and instanced once.

Test Plan (WIDTH=16):
- 0xFFFF + 0x0001, cin=0 -> out_valid 4 edges after accept; sum=0x0000, carry=1; all nibbles carry-propagated.
- 0x1234 + 0x4321, cin=1 -> sum=0x5556, carry=0. Hold out_ready=0 for 3 cycles: out_valid, sum and carry stay stable; in_ready stays 0.
- Back-to-back requests with in_valid held high and out_ready=1 -> second accept occurs one cycle after DONE exits. a/b changed after the first accept do not alter result 1.
- Reset asserted during RUN (after 2 nibbles) -> outputs zero immediately, in_ready=1. A fresh request 0x0F0F+0xF0F0 then gives sum=0xFFFF, carry=0.
- With WIDE_ADD_SUB_EN:
  - 0x0005 - 0x0007 -> sum=0xFFFE, carry=0.
  - 0x8000 - 0x0001 -> sum=0x7FFF, carry=1.

Source files
------------

// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared definitions for the nibble-serial adder.
//   state_t  - sequencer states (IDLE, RUN, DONE)
//   NIBBLE_W - width of the shared adder slice
//   nibbles  - number of slice passes needed for a given operand width
package wide_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int unsigned NIBBLE_W = 4;

   function automatic int unsigned nibbles(input int unsigned width);
      return width / NIBBLE_W;
   endfunction

endpackage

// File: rtl/wide_add_seq_add4_slice.sv
// add4_slice: combinational 4-bit ripple-carry adder made of 1-bit full adders.
// Ports:
//   a4, b4 : slice operands
//   ci     : carry-in
//   s4     : slice sum
//   co     : carry-out of the top bit
module add4_slice
   import wide_add_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a4,
   input  logic [NIBBLE_W-1:0] b4,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s4,
   output logic                co
);

   logic [NIBBLE_W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign s4[i]   = a4[i] ^ b4[i] ^ c[i];
      assign c[i+1]  = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
   end

   assign co = c[NIBBLE_W];

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: WIDTH-bit adder that time-shares one 4-bit slice, one nibble
// per clock, LSB first. Operands are captured on accept; the result appears
// NIBBLES edges later with out_valid held until out_ready.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, cin           : operands and carry-in
//   op_sub              : subtract select (only with WIDE_ADD_SUB_EN defined)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, carry          : registered result and final carry-out
//   busy                : high in RUN or DONE
// Build option: `define WIDE_ADD_SUB_EN adds op_sub (a - b, carry = no borrow).
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int unsigned WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef WIDE_ADD_SUB_EN
   input  logic             op_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             busy
);

   localparam int unsigned NIBBLES = nibbles(WIDTH);
   localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t state, state_nxt;

   logic [WIDTH-1:0]    a_reg;
   logic [WIDTH-1:0]    b_reg;
   logic [IDX_W-1:0]    idx;
   logic [NIBBLE_W-1:0] s4;
   logic                co;

   add4_slice u_slice (
      .a4 (a_reg[NIBBLE_W*idx +: NIBBLE_W]),
      .b4 (b_reg[NIBBLE_W*idx +: NIBBLE_W]),
      .ci (carry),
      .s4 (s4),
      .co (co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (idx == LAST_IDX) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // carry doubles as the inter-nibble carry register and the final carry-out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         idx   <= '0;
         sum   <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  idx   <= '0;
`ifdef WIDE_ADD_SUB_EN
                  // a - b computed as a + ~b + 1
                  b_reg <= op_sub ? ~b : b;
                  carry <= op_sub | cin;
`else
                  b_reg <= b;
                  carry <= cin;
`endif
               end
            end
            RUN: begin
               sum[NIBBLE_W*idx +: NIBBLE_W] <= s4;
               carry <= co;
               idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
